// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong frame buffer controller.
// The writer fills one half of a dual-port RAM with PCM samples. The reader
// streams the other half out once that half is full. Each RAM half holds
// HALF_LEN samples at addresses {half, idx[7:0]}. A sample that arrives while
// the target half is still waiting to be read is dropped, and the sticky
// overflow flag records the loss.

module pingpong_buf_ctrl #(
  parameter int HALF_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        din_valid,
  input  logic [15:0] din,
  input  logic        ovf_clr,
  output logic        ram_cea,
  output logic [8:0]  ram_ada,
  output logic [15:0] ram_din,
  output logic        ram_ceb,
  output logic        ram_oce,
  output logic [8:0]  ram_adb,
  input  logic [15:0] ram_dout,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        out_half,
  output logic        overflow
);

  localparam logic [7:0] LAST_IDX = 8'(HALF_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  // writer state
  logic       r_wr_half;
  logic [7:0] r_wr_cnt;
  // reader state
  rd_state_t  r_state;
  logic       r_rd_half;
  logic [7:0] r_rd_cnt;
  // one bit per half: written completely and not yet read out
  logic [1:0] r_full;
  logic       r_overflow;
  // registered frame-output qualifiers
  logic       r_out_valid;
  logic       r_out_first;
  logic       r_out_last;
  logic       r_out_half;

  logic       w_wr_req;
  logic       w_wr_acc;
  logic       w_wr_drop;
  logic       w_wr_done;
  logic       w_rd_active;
  logic       w_rd_done;
  logic [1:0] w_full_set;
  logic [1:0] w_full_clr;

  // A write is requested only while capture is enabled. It is never issued
  // during a reset cycle, so that a reset leaves the RAM untouched.
  assign w_wr_req    = din_valid & en & ~reset;
  assign w_wr_acc    = w_wr_req & ~r_full[r_wr_half];
  assign w_wr_drop   = w_wr_req &  r_full[r_wr_half];
  assign w_wr_done   = w_wr_acc & (r_wr_cnt == LAST_IDX);
  assign w_rd_active = (r_state == ST_READ);
  assign w_rd_done   = w_rd_active & (r_rd_cnt == LAST_IDX);

  // The writer only ever completes the half that the reader is not draining,
  // so a set and a clear in the same cycle always hit different bits.
  assign w_full_set = w_wr_done ? (r_wr_half ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_clr = w_rd_done ? (r_rd_half ? 2'b10 : 2'b01) : 2'b00;

  // The write port is driven combinationally from the incoming sample.
  assign ram_cea = w_wr_acc;
  assign ram_ada = {r_wr_half, r_wr_cnt};
  assign ram_din = din;

  // The read port is driven directly from the reader state.
  assign ram_ceb = w_rd_active;
  assign ram_adb = {r_rd_half, r_rd_cnt};
  assign ram_oce = 1'b1;

  // RAM read data arrives one cycle after the address, aligned with r_out_valid.
  assign out_data  = ram_dout;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign out_half  = r_out_half;
  assign overflow  = r_overflow;

  // Writer: advance the sample index and hand the half over when it fills up.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_half <= 1'b0;
      r_wr_cnt  <= 8'd0;
    end else if (w_wr_done) begin
      r_wr_half <= ~r_wr_half;
      r_wr_cnt  <= 8'd0;
    end else if (w_wr_acc) begin
      r_wr_cnt  <= r_wr_cnt + 8'd1;
    end
  end

  // Full flags: the writer sets a flag and the reader clears one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  // Sticky overflow: a drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_wr_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Reader FSM: stream one full half out without stalls, then go back to
  // IDLE for at least one cycle. The output qualifiers are registered from
  // the cycle that issues the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rd_half   <= 1'b0;
      r_rd_cnt    <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_half  <= 1'b0;
    end else begin
      r_out_valid <= w_rd_active;
      r_out_first <= w_rd_active & (r_rd_cnt == 8'd0);
      r_out_last  <= w_rd_done;
      r_out_half  <= r_rd_half;
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rd_half]) begin
            r_state  <= ST_READ;
            r_rd_cnt <= 8'd0;
          end
        end
        ST_READ: begin
          if (r_rd_cnt == LAST_IDX) begin
            r_state   <= ST_IDLE;
            r_rd_half <= ~r_rd_half;
          end else begin
            r_rd_cnt  <= r_rd_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
